aes_dec_round_ctrl: RTL and testbench
=====================================

AES_DEC_ROUND_CTRL -- requirements
Module: aes_dec_round_ctrl

Interface
REQ-001 Parameter NR, default 10; number of cipher rounds; legal values 10, 12, 14.
REQ-002 clk  input  1  Sole clock; all state updates on rising edge.
REQ-003 rst  input  1  Synchronous, active-high reset.
REQ-004 in_valid  input  1  Ciphertext block present on the external datapath input.
REQ-005 in_ready  output  1  Controller can accept a block.
REQ-006 key_valid  input  1  Round key addressed by key_idx is available this cycle.
REQ-007 key_idx  output  4  Round-key index requested from the key store.
REQ-008 ld_sel  output  1  1 = state register loads ciphertext XOR key; 0 = loads round-logic result.
REQ-009 st_en  output  1  State register write enable.
REQ-010 mix_en  output  1  1 = InvMixColumns applied in this round; 0 = bypassed.
REQ-011 out_valid  output  1  Plaintext in the state register is valid.
REQ-012 out_ready  input  1  Consumer accepts plaintext.
REQ-013 busy  output  1  High in every state except IDLE.

Function
REQ-014 FSM states are IDLE, INIT, ROUND, FINAL and DONE, with a round counter rnd[3:0].
REQ-015 IDLE: in_ready=1; on in_valid, go to INIT with rnd=NR.
REQ-016 INIT: key_idx=NR, ld_sel=1, mix_en=0, st_en=key_valid; when key_valid, go to ROUND with rnd=NR-1.
REQ-017 ROUND: key_idx=rnd, ld_sel=0, mix_en=1, st_en=key_valid; when key_valid, rnd decrements and the FSM goes to FINAL if rnd==1, else stays in ROUND.
REQ-018 FINAL: key_idx=0, ld_sel=0, mix_en=0, st_en=key_valid; when key_valid, go to DONE.
REQ-019 DONE: out_valid=1; when out_ready, go to IDLE; otherwise hold with no state writes.
REQ-020 key_valid=0 in INIT, ROUND or FINAL: st_en=0, and state and rnd hold (stall); there is no timeout.
REQ-021 With no stalls, a block accepted at cycle T gives out_valid at T+NR+2 (T+12 for NR=10).
REQ-022 in_ready is 0 outside IDLE, so a second block is never accepted mid-operation.
REQ-023 A DONE->IDLE transition and a new in_valid accept on the next cycle (no bubble beyond the IDLE cycle).
REQ-024 key_idx never exceeds NR and never underflows below 0.
REQ-025 Outputs are decoded from registered state only (Moore), except st_en, which also depends on key_valid.
REQ-026 In IDLE and DONE, st_en=0, mix_en=0, ld_sel=0 and key_idx=0.

Reset
REQ-027 While rst=1 at a clock edge, the next state is IDLE and rnd=0, regardless of current state, including mid-round or DONE.
REQ-028 Output values after reset: in_ready=1, out_valid=0, busy=0, st_en=0, mix_en=0, ld_sel=0, key_idx=0.
REQ-029 rst takes priority over all inputs, including in_valid and out_ready in the same cycle.

Configuration
REQ-030 Macro AES_DEC_ABORT_EN, when defined, adds the port abort (input, 1 bit, same clock).
REQ-031 With AES_DEC_ABORT_EN defined, abort=1 in any non-IDLE state forces IDLE on the next edge, out_valid=0 and st_en=0 that cycle.
REQ-032 With AES_DEC_ABORT_EN defined, abort is ignored in IDLE, and rst has priority over abort.
REQ-033 Without AES_DEC_ABORT_EN, the abort port does not exist and behaviour is exactly REQ-014..REQ-029.

Verification
REQ-034 Reset 3 cycles, then in_valid=1 at T with key_valid=1 and out_ready=1 -> key_idx sequence 10,9,...,1,0; mix_en=1 only for idx 9..1; out_valid=1 at T+12 for exactly 1 cycle.
REQ-035 Same stimulus with key_valid=0 for 3 cycles at rnd=5 -> st_en=0 for those 3 cycles, key_idx holds 5, out_valid at T+15.
REQ-036 out_ready=0 for 4 cycles in DONE -> out_valid held 5 cycles, in_ready=0 and st_en=0 throughout.
REQ-037 rst=1 during ROUND at rnd=6 -> next cycle IDLE, in_ready=1, key_idx=0, busy=0.
REQ-038 NR=14 build -> first key_idx 14, out_valid at T+16.
REQ-039 With AES_DEC_ABORT_EN, abort=1 at rnd=3 -> IDLE next cycle, out_valid never asserted, and a following block completes normally.

Source files
------------

// File: rtl/aes_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_dec_round_ctrl
// Purpose  : Round sequencer for an iterative AES decryption datapath. It
//            accepts one ciphertext block, requests round keys from NR down
//            to 0, steers the state register between the initial key XOR and
//            the round logic, and enables InvMixColumns only in the middle
//            rounds. It then holds the plaintext valid until it is consumed.
// Revision : 1.0 - initial release
//
// Parameters
//   NR         number of cipher rounds (10, 12 or 14)
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   ciphertext block offered       in_ready   block can be accepted
//   key_valid  round key key_idx is available key_idx    round-key index
//   ld_sel     1 = load ciphertext ^ key, 0 = load round-logic result
//   st_en      state register write enable
//   mix_en     apply InvMixColumns this round
//   out_valid  plaintext valid                 out_ready  consumer accepts it
//   busy       controller is not idle
//   abort      (only with AES_DEC_ABORT_EN) drop the current block
// Build option
//   AES_DEC_ABORT_EN  adds the abort input
// ============================================================================
module aes_dec_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       key_valid,
  output logic [3:0] key_idx,
  output logic       ld_sel,
  output logic       st_en,
  output logic       mix_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
`ifdef AES_DEC_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] NR_M1IDX = 4'(NR - 1);

  if ((NR != 10) && (NR != 12) && (NR != 14)) begin : g_bad_nr
    $error("aes_dec_round_ctrl: NR must be 10, 12 or 14");
  end

  logic [2:0] state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       abort_act;

`ifdef AES_DEC_ABORT_EN
  // Abort has no meaning while idle, so it is qualified by the state.
  assign abort_act = abort && (state_q != S_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Every key-consuming state stalls while key_valid is low.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_INIT;
          rnd_d   = NR_IDX;
        end
      end
      S_INIT: begin
        if (key_valid) begin
          state_d = S_ROUND;
          rnd_d   = NR_M1IDX;
        end
      end
      S_ROUND: begin
        if (key_valid) begin
          // Testing <= 1 rather than == 1 keeps rnd from ever wrapping below 0.
          if (rnd_q <= 4'd1) begin
            state_d = S_FINAL;
            rnd_d   = 4'd0;
          end else begin
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
      S_FINAL: begin
        if (key_valid) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        rnd_d   = 4'd0;
      end
    endcase

    if (abort_act) begin
      state_d = S_IDLE;
      rnd_d   = 4'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode: registered state only, except st_en which follows key_valid.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    key_idx   = 4'd0;
    ld_sel    = 1'b0;
    st_en     = 1'b0;
    mix_en    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_INIT: begin
        key_idx = NR_IDX;
        ld_sel  = 1'b1;
        st_en   = key_valid && !abort_act;
      end
      S_ROUND: begin
        key_idx = rnd_q;
        mix_en  = 1'b1;
        st_en   = key_valid && !abort_act;
      end
      S_FINAL: begin
        st_en = key_valid && !abort_act;
      end
      S_DONE: begin
        out_valid = !abort_act;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_dec_round_ctrl
// Purpose  : Self-checking bench for aes_dec_round_ctrl. A table of per-cycle
//            input/expected-output records is replayed against an NR=10
//            instance through a scoreboard queue; an NR=14 instance is checked
//            by a hand-written sequence. Abort cases are built only when
//            AES_DEC_ABORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_dec_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, key_valid, out_ready;
  logic       in_ready, ld_sel, st_en, mix_en, out_valid, busy;
  logic [3:0] key_idx;
  logic       in_valid14;
  logic       in_ready14, ld_sel14, st_en14, mix_en14, out_valid14, busy14;
  logic [3:0] key_idx14;
`ifdef AES_DEC_ABORT_EN
  logic       abort;
`endif

  aes_dec_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key_valid(key_valid), .key_idx(key_idx), .ld_sel(ld_sel), .st_en(st_en),
    .mix_en(mix_en), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef AES_DEC_ABORT_EN
    , .abort(abort)
`endif
  );

  aes_dec_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14),
    .key_valid(key_valid), .key_idx(key_idx14), .ld_sel(ld_sel14), .st_en(st_en14),
    .mix_en(mix_en14), .out_valid(out_valid14), .out_ready(out_ready), .busy(busy14)
`ifdef AES_DEC_ABORT_EN
    , .abort(1'b0)
`endif
  );

  // Expected vector packing: {in_ready, busy, key_idx[3:0], ld_sel, st_en, mix_en, out_valid}
  typedef struct {
    string      nm;
    logic       r, iv, kv, ordy, ab;
    logic [9:0] exp;
  } vec_t;

  vec_t       tbl[$];
  string      sb_nm[$];
  logic [9:0] sb_exp[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic void add(string nm, logic r, logic iv, logic kv, logic ordy,
                              logic ab, logic [9:0] e);
    vec_t v;
    v.nm = nm; v.r = r; v.iv = iv; v.kv = kv; v.ordy = ordy; v.ab = ab; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic void e_idle(string nm, logic r, logic iv, logic kv, logic ordy, logic ab);
    add(nm, r, iv, kv, ordy, ab, {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
  endfunction
  function automatic void e_init(string nm, logic r, logic iv, logic kv, logic ordy, logic ab);
    add(nm, r, iv, kv, ordy, ab, {1'b0, 1'b1, 4'd10, 1'b1, kv & ~ab, 1'b0, 1'b0});
  endfunction
  function automatic void e_round(string nm, logic r, logic iv, logic [3:0] idx, logic kv, logic ab);
    add(nm, r, iv, kv, 1'b1, ab, {1'b0, 1'b1, idx, 1'b0, kv & ~ab, 1'b1, 1'b0});
  endfunction
  function automatic void e_final(string nm, logic r, logic iv, logic kv, logic ordy, logic ab);
    add(nm, r, iv, kv, ordy, ab, {1'b0, 1'b1, 4'd0, 1'b0, kv & ~ab, 1'b0, 1'b0});
  endfunction
  function automatic void e_done(string nm, logic r, logic iv, logic kv, logic ordy, logic ab);
    add(nm, r, iv, kv, ordy, ab, {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, ~ab});
  endfunction

  function automatic void rounds(string nm, int hi, int lo);
    for (int i = hi; i >= lo; i--) e_round(nm, 1'b0, 1'b0, 4'(i), 1'b1, 1'b0);
  endfunction

  // One unstalled block: accept cycle T, INIT at T+1, rounds 9..1, FINAL, DONE at T+12.
  function automatic void full_block(string nm);
    e_idle({nm, "_accept"}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_init({nm, "_init"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rounds({nm, "_round"}, 9, 1);
    e_final({nm, "_final"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    e_done({nm, "_done"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  // Scoreboard consumer: compares away from the rising edge.
  always @(negedge clk) begin
    #2;
    if (sb_exp.size() > 0) begin
      logic [9:0] e, a;
      string      nm;
      e  = sb_exp.pop_front();
      nm = sb_nm.pop_front();
      a  = {in_ready, busy, key_idx, ld_sel, st_en, mix_en, out_valid};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got {ir,busy,idx,ld,st,mix,ov}=%b required %b", nm, a, e);
      end
    end
  end

  task automatic check14(string nm, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; key_valid = 1'b0; out_ready = 1'b0; in_valid14 = 1'b0;
`ifdef AES_DEC_ABORT_EN
    abort = 1'b0;
`endif

    // ---------------- vector table ----------------
    e_idle("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    full_block("nom");
    e_idle("nom_idle_after", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Key stall for 3 cycles at rnd=5: DONE lands at T+15.
    e_idle("stall_accept", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_init("stall_init", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rounds("stall_round", 9, 6);
    for (int i = 0; i < 3; i++) e_round("stall_hold5", 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
    rounds("stall_round", 5, 1);
    e_final("stall_final", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    e_done("stall_done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    e_idle("stall_idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Stalls in INIT/FINAL, DONE held 5 cycles with in_valid high, then back-to-back block.
    e_idle("hold_accept", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_init("hold_init_stall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    e_init("hold_init_stall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    e_init("hold_init", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rounds("hold_round", 9, 1);
    e_final("hold_final_stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e_final("hold_final", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) e_done("hold_done_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    e_done("hold_done_take", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    full_block("b2b");
    e_idle("b2b_idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset at rnd=6 in ROUND.
    e_idle("rstmid_accept", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_init("rstmid_init", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rounds("rstmid_round", 9, 7);
    e_round("rstmid_rnd6_rst", 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
    e_idle("rstmid_idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset in DONE beats out_ready/in_valid; reset in IDLE beats in_valid.
    e_idle("rstdone_accept", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_init("rstdone_init", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rounds("rstdone_round", 9, 1);
    e_final("rstdone_final", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_done("rstdone_done_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    e_idle("rstdone_idle_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    e_idle("rstidle_still_idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

`ifdef AES_DEC_ABORT_EN
    e_idle("abort_accept", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_init("abort_init", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rounds("abort_round", 9, 4);
    e_round("abort_rnd3", 1'b0, 1'b0, 4'd3, 1'b1, 1'b1);
    e_idle("abort_idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    full_block("abort_next");
    e_idle("abort_idle_ignored", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    e_init("abort_ign_init", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rounds("abort_ign_round", 9, 1);
    e_final("abort_ign_final", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_done("abort_in_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    e_idle("abort_done_idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    repeat (3) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst       = tbl[i].r;
      in_valid  = tbl[i].iv;
      key_valid = tbl[i].kv;
      out_ready = tbl[i].ordy;
`ifdef AES_DEC_ABORT_EN
      abort     = tbl[i].ab;
`endif
      sb_nm.push_back(tbl[i].nm);
      sb_exp.push_back(tbl[i].exp);
    end
    @(negedge clk);
    in_valid = 1'b0;
`ifdef AES_DEC_ABORT_EN
    abort = 1'b0;
`endif
    #5;
    n_tests++;
    if (sb_exp.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending required 0", sb_exp.size());
    end

    // ---------------- NR=14 instance ----------------
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; key_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid14 = 1'b1;
    #2;
    check14("nr14_in_ready", 32'(in_ready14), 32'd1);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid14 = 1'b0;
      #2;
      if (c == 1) check14("nr14_first_idx", 32'(key_idx14), 32'd14);
      if (out_valid14) begin
        n = c;
        break;
      end
    end
    check14("nr14_latency", 32'(n), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
